// File: rtl/rr_grant_encoder.sv
// rr_grant_encoder: round-robin request picker that offers a held grant (index + one-hot) until acknowledged.
// Optional macro RR_ENC_LOCK_EN adds a LOCK state that keeps the grant after ack while its request stays high.
module rr_grant_encoder #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             ack,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [WIDTH-1:0] grant_onehot,
    output logic             load
);
    typedef enum logic [1:0] {IDLE, OFFER, LOCK} state_t;
    state_t           state_q;
    logic [IDX_W-1:0] ptr_q, grant_idx_q, pick_idx, ptr_nxt, j;
    logic [WIDTH-1:0] grant_onehot_q;
    logic             grant_valid_q, load_q, hold, done;
    int               s;
    assign grant_valid  = grant_valid_q;
    assign grant_idx    = grant_idx_q;
    assign grant_onehot = grant_onehot_q;
    assign load         = load_q;
    // Rotating priority scan from ptr (highest offset first so the nearest requester wins), plus release decode.
    always_comb begin
        pick_idx = '0;
        s        = 0;
        j        = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            s = int'(ptr_q) + k;
            s = (s >= WIDTH) ? s - WIDTH : s;
            j = IDX_W'(s);
            if (req[j]) pick_idx = j;
        end
        ptr_nxt = (int'(grant_idx_q) >= WIDTH - 1) ? '0 : grant_idx_q + 1'b1;
`ifdef RR_ENC_LOCK_EN
        hold = req[grant_idx_q];
`else
        hold = 1'b0;
`endif
        done = (state_q == OFFER && ack && !hold) || (state_q == LOCK && !req[grant_idx_q]);
    end
    // Grant FSM with registered outputs; a release advances the pointer and clears the grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
            grant_valid_q  <= 1'b0;
            load_q         <= 1'b0;
        end else begin
            load_q <= 1'b0;
            if (state_q == IDLE && |req) begin
                grant_idx_q    <= pick_idx;
                grant_onehot_q <= WIDTH'(1) << pick_idx;
                grant_valid_q  <= 1'b1;
                load_q         <= 1'b1;
                state_q        <= OFFER;
            end
            if (state_q == OFFER && ack && hold) state_q <= LOCK;
            if (done) begin
                ptr_q          <= ptr_nxt;
                grant_valid_q  <= 1'b0;
                grant_onehot_q <= '0;
                state_q        <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_rr_grant_encoder.sv
// tb_rr_grant_encoder: directed test-plan steps plus randomized traffic checked against a behavioural model.
module tb_rr_grant_encoder;
    localparam int W = 4, IW = 2;
    logic clk = 0, rst = 0, ack = 0;
    logic [W-1:0] req = '0;
    logic gv, ld;
    logic [IW-1:0] gi;
    logic [W-1:0] go;
    int compared = 0, mismatched = 0;
    int m_ptr, m_idx;
    bit m_valid, m_load, m_lock;

    rr_grant_encoder #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack),
        .grant_valid(gv), .grant_idx(gi), .grant_onehot(go), .load(ld)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(int p, logic [W-1:0] r);
        for (int k = 0; k < W; k++) if (r[(p + k) % W]) return (p + k) % W;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_idx = 0; m_valid = 0; m_load = 0; m_lock = 0;
    endtask

    task automatic model_release();
        m_ptr = (m_idx + 1) % W; m_valid = 0; m_lock = 0;
    endtask

    task automatic model_edge();
        m_load = 0;
        if (!m_valid) begin
            if (req != 0) begin m_idx = pick(m_ptr, req); m_valid = 1; m_load = 1; end
        end else if (m_lock) begin
            if (!req[m_idx]) model_release();
        end else if (ack) begin
`ifdef RR_ENC_LOCK_EN
            if (req[m_idx]) m_lock = 1; else model_release();
`else
            model_release();
`endif
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, ".valid"}, gv, m_valid);
        chk({tag, ".idx"}, gi, m_idx);
        chk({tag, ".onehot"}, go, m_valid ? (1 << m_idx) : 0);
        chk({tag, ".load"}, ld, m_load);
    endtask

    task automatic expect_g(string tag, bit v, int i, int oh, bit l);
        chk({tag, ".v"}, gv, v);
        chk({tag, ".i"}, gi, i);
        chk({tag, ".oh"}, go, oh);
        chk({tag, ".ld"}, ld, l);
    endtask

    task automatic tick(string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        #2 rst = 0;
        model_reset();
        #1 expect_g("rst_async", 0, 0, 0, 0);
        #2 rst = 1;
    endtask

    initial begin
        model_reset();
        #3 expect_g("por", 0, 0, 0, 0);
        #9 rst = 1;
        // 1: mid-OFFER reset restarts the pointer at 0
        req = 4'b0010; tick("t1a"); expect_g("t1a", 1, 1, 4'b0010, 1);
        req = 4'b0000; ack = 1; tick("t1b"); expect_g("t1b", 0, 1, 0, 0);
        ack = 0; req = 4'b0100; tick("t1c"); expect_g("t1c", 1, 2, 4'b0100, 1);
        tick("t1d"); expect_g("t1d", 1, 2, 4'b0100, 0);
        do_reset();
        req = 4'b0110; tick("t1e"); expect_g("t1e", 1, 1, 4'b0010, 1);
        req = 4'b0000; ack = 1; tick("t1f");
        ack = 0; tick("t1g");
`ifndef RR_ENC_LOCK_EN
        // 2: rotation with req held
        do_reset();
        req = 4'b0101; tick("t2a"); expect_g("t2a", 1, 0, 4'b0001, 1);
        ack = 1; tick("t2b"); expect_g("t2b", 0, 0, 0, 0);
        tick("t2c"); expect_g("t2c", 1, 2, 4'b0100, 1);
        tick("t2d"); expect_g("t2d", 0, 2, 0, 0);
        ack = 0; tick("t2e"); expect_g("t2e", 1, 0, 4'b0001, 1);
        ack = 1; req = 4'b0000; tick("t2f"); ack = 0;
`endif
        // 3: wrap-around
        do_reset();
        req = 4'b1000; tick("t3a"); expect_g("t3a", 1, 3, 4'b1000, 1);
        req = 4'b0000; ack = 1; tick("t3b"); expect_g("t3b", 0, 3, 0, 0);
        ack = 0; req = 4'b1001; tick("t3c"); expect_g("t3c", 1, 0, 4'b0001, 1);
        req = 4'b0000; ack = 1; tick("t3d"); ack = 0;
        // 4: withdrawal does not revoke
        do_reset();
        req = 4'b0010; tick("t4a"); expect_g("t4a", 1, 1, 4'b0010, 1);
        req = 4'b0000;
        for (int c = 0; c < 5; c++) begin tick("t4h"); expect_g("t4h", 1, 1, 4'b0010, 0); end
        ack = 1; tick("t4b"); expect_g("t4b", 0, 1, 0, 0);
        // 5: spurious ack, then full-request rotation with ack held
        tick("t5a"); expect_g("t5a", 0, 1, 0, 0);
`ifndef RR_ENC_LOCK_EN
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < W; g++) begin
            tick("t5g"); expect_g("t5g", 1, g, 1 << g, 1);
            tick("t5i"); expect_g("t5i", 0, g, 0, 0);
        end
`endif
        ack = 0; req = 4'b0000;
        // 6: lock behaviour
        do_reset();
        req = 4'b0010; tick("t6a"); expect_g("t6a", 1, 1, 4'b0010, 1);
        ack = 1; tick("t6b");
`ifdef RR_ENC_LOCK_EN
        expect_g("t6b", 1, 1, 4'b0010, 0);
        tick("t6c"); expect_g("t6c", 1, 1, 4'b0010, 0);
        req = 4'b0000; tick("t6d"); expect_g("t6d", 0, 1, 0, 0);
        ack = 0; req = 4'b0110; tick("t6e"); expect_g("t6e", 1, 2, 4'b0100, 1);
`else
        expect_g("t6b", 0, 1, 0, 0);
        ack = 0; tick("t6c"); expect_g("t6c", 1, 1, 4'b0010, 1);
`endif
        ack = 1; req = 4'b0000; tick("t6f"); ack = 0;
        // randomized traffic against the model
        do_reset();
        repeat (800) begin
            if ($urandom_range(0, 3) == 0) req = W'($urandom);
            ack = ($urandom_range(0, 2) == 0);
            tick("rnd");
            if ($urandom_range(0, 99) == 0) do_reset();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rr_grant_encoder.md
Name: rr_grant_encoder

Overview:
Request-side counterpart of the grant decoder in the round-robin arbiter.
- Samples a WIDTH-bit request vector and picks one requester in round-robin order.
- Presents the pick as a binary index plus a one-hot vector, and pulses load for the downstream grant register.
- Holds the grant until the consumer acknowledges it, then advances the priority pointer.

Parameters:
WIDTH, 4, number of requesters (>= 2).
IDX_W, 2, index width; must equal ceil(log2(WIDTH)).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
req  input  WIDTH  request vector, bit i = requester i.
ack  input  1  consumer accepts current grant.
grant_valid  output  1  grant outputs are valid and stable.
grant_idx  output  IDX_W  binary index of granted requester.
grant_onehot  output  WIDTH  one-hot of granted requester.
load  output  1  single-cycle pulse on the first cycle of each new grant.

Behaviour:
- Clock is clk; reset is rst, asynchronous, active-low.
- Reset clears all state and outputs: grant_valid=0, grant_idx=0, grant_onehot=0, load=0, ptr=0, state=IDLE. Reset takes effect immediately, including mid-grant; any in-flight grant is discarded.
- ptr is internal, IDX_W bits: the highest-priority index for the next pick.
- Pick rule: first i with req[i]=1, scanning ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1. Arithmetic is modulo WIDTH; non-power-of-2 WIDTH must never yield an index >= WIDTH.
- IDLE:
  - If req != 0, register the pick into grant_idx and grant_onehot, set grant_valid=1 and load=1, then go to OFFER.
  - If req == 0, stay in IDLE.
  - ack is ignored in IDLE.
- OFFER:
  - load=0 after its first cycle. grant_idx, grant_onehot and grant_valid stay constant.
  - Withdrawal of req[grant_idx] does not revoke the grant.
  - Changes on other req bits are ignored.
- OFFER with ack=1 at a clock edge:
  - ptr <= (grant_idx+1) mod WIDTH.
  - grant_valid <= 0, grant_onehot <= 0. grant_idx holds its last value.
  - Go to IDLE.
- Latency:
  - req seen in IDLE -> grant_valid and load high one cycle later.
  - After ack there is at least one cycle with grant_valid=0 before the next grant. No back-to-back grants.
- Invariants:
  - grant_onehot is always zero or exactly one-hot, and equals 1<<grant_idx whenever grant_valid=1.
  - load=1 implies grant_valid=1.
- Fairness: with all requests held high, grants cycle 0,1,...,WIDTH-1,0,...

Optional Feature:
RR_ENC_LOCK_EN.
- Defined: adds a LOCK state.
  - On ack in OFFER, if req[grant_idx] is still 1, go to LOCK instead of IDLE. grant_valid stays 1, no new load pulse, and ptr is not yet updated.
  - In LOCK, ack is ignored. When req[grant_idx]=0, do the ptr update and grant clear described for ack in OFFER, then go to IDLE.
- Not defined: no LOCK state exists; ack in OFFER always returns to IDLE.

Test Plan:
1. Reset (WIDTH=4): assert rst=0 mid-OFFER -> grant_valid=0, grant_onehot=0000, load=0 immediately; after release, req=0010 -> grant_idx=1 (ptr restarted at 0).
2. Rotation: from reset, req=0101 held. Expected sequence:
   - grant_idx=0, onehot=0001, load pulse.
   - ack -> one idle cycle.
   - grant_idx=2, onehot=0100.
   - ack -> grant_idx=0 again.
3. Wrap-around: req=1000 -> idx=3; ack (ptr=0); then req=1001 -> idx=0.
4. Withdrawal: grant idx=1 issued, req drops to 0000 during OFFER -> outputs held for 5 cycles until ack, then grant_valid=0.
5. Spurious ack: ack=1 in IDLE with req=0000 -> no change. req=1111 with ack held high -> grants 0,1,2,3 with one idle cycle between each.
6. RR_ENC_LOCK_EN defined: req=0010 held, ack -> grant_valid stays 1, no load pulse. req drops -> grant_valid=0 next cycle, ptr=2. Not defined: same stimulus -> grant_valid=0 right after ack, and a fresh grant idx=1 with load pulse one cycle later.
